// File: rtl/id_issue_stage_if.sv
// Execute-side bus of the issue stage: the registered decode result plus the
// valid/ready handshake into the execute stage.
interface id_issue_stage_if #(parameter int XLEN = 32);
    logic            ex_valid;
    logic            ex_ready;
    logic [7:0]      aluop;
    logic [2:0]      alusel;
    logic [XLEN-1:0] reg1;
    logic [XLEN-1:0] reg2;
    logic [4:0]      wd;
    logic            wreg;
    logic [XLEN-1:0] pc;
    logic            illegal;

    modport master (
        output ex_valid, aluop, alusel, reg1, reg2, wd, wreg, pc, illegal,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, aluop, alusel, reg1, reg2, wd, wreg, pc, illegal,
        output ex_ready
    );
endinterface

// File: rtl/id_issue_stage.sv
// Decode/issue stage: decodes RV32I/RV64I logic, shift and LUI instructions,
// forwards operands, detects load-use hazards and feeds execute via a pipeline register.
module id_issue_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int PERF_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inst_valid_i,
    input  logic [XLEN-1:0]         pc_i,
    input  logic [31:0]             inst_i,
    output logic                    id_ready_o,
    output logic                    reg1_read_o,
    output logic                    reg2_read_o,
    output logic [4:0]              reg1_addr_o,
    output logic [4:0]              reg2_addr_o,
    input  logic [XLEN-1:0]         reg1_data_i,
    input  logic [XLEN-1:0]         reg2_data_i,
    input  logic [NUM_FWD-1:0]      fwd_wreg_i,
    input  logic [5*NUM_FWD-1:0]    fwd_wd_i,
    input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
    input  logic [NUM_FWD-1:0]      fwd_rdy_i,
    input  logic                    flush_i,
    id_issue_stage_if.master        ex,
    output logic [PERF_W-1:0]       stall_cnt_o
);

    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    logic [7:0]      dec_aluop;
    logic [2:0]      dec_alusel;
    logic            dec_wreg;
    logic            dec_illegal;
    logic [XLEN-1:0] imm;
    logic [5:0]      shamt;
    logic            shamt_ok;
    logic [XLEN:0]   op1;
    logic [XLEN:0]   op2;
    logic            hazard;
    logic            accept;

    always_comb begin
        shamt    = (XLEN == 64) ? inst_i[25:20] : {1'b0, inst_i[24:20]};
        shamt_ok = (XLEN == 64) || !inst_i[25];
    end

    // Illegal encodings fall through to a harmless NOP that reads and writes nothing.
    always_comb begin
        dec_aluop   = EXE_NOP_OP;
        dec_alusel  = EXE_RES_NOP;
        dec_wreg    = 1'b0;
        dec_illegal = 1'b1;
        reg1_read_o = 1'b0;
        reg2_read_o = 1'b0;
        reg1_addr_o = inst_i[19:15];
        reg2_addr_o = inst_i[24:20];
        imm         = '0;
        case (inst_i[6:0])
            OPC_OP_IMM: begin
                reg1_read_o = 1'b1;
                imm         = XLEN'($signed(inst_i[31:20]));
                case (inst_i[14:12])
                    3'b110: begin dec_aluop = EXE_OR_OP;  dec_alusel = EXE_RES_LOGIC; dec_illegal = 1'b0; end
                    3'b111: begin dec_aluop = EXE_AND_OP; dec_alusel = EXE_RES_LOGIC; dec_illegal = 1'b0; end
                    3'b100: begin dec_aluop = EXE_XOR_OP; dec_alusel = EXE_RES_LOGIC; dec_illegal = 1'b0; end
                    3'b001: begin
                        imm = {{(XLEN-6){1'b0}}, shamt};
                        if (inst_i[31:26] == 6'b000000 && shamt_ok) begin
                            dec_aluop = EXE_SLL_OP; dec_alusel = EXE_RES_SHIFT; dec_illegal = 1'b0;
                        end
                    end
                    3'b101: begin
                        imm = {{(XLEN-6){1'b0}}, shamt};
                        if (inst_i[31:26] == 6'b000000 && shamt_ok) begin
                            dec_aluop = EXE_SRL_OP; dec_alusel = EXE_RES_SHIFT; dec_illegal = 1'b0;
                        end else if (inst_i[31:26] == 6'b010000 && shamt_ok) begin
                            dec_aluop = EXE_SRA_OP; dec_alusel = EXE_RES_SHIFT; dec_illegal = 1'b0;
                        end
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_OP: begin
                reg1_read_o = 1'b1;
                reg2_read_o = 1'b1;
                case (inst_i[14:12])
                    3'b110: if (inst_i[31:25] == 7'b0000000) begin dec_aluop = EXE_OR_OP;  dec_alusel = EXE_RES_LOGIC; dec_illegal = 1'b0; end
                    3'b111: if (inst_i[31:25] == 7'b0000000) begin dec_aluop = EXE_AND_OP; dec_alusel = EXE_RES_LOGIC; dec_illegal = 1'b0; end
                    3'b100: if (inst_i[31:25] == 7'b0000000) begin dec_aluop = EXE_XOR_OP; dec_alusel = EXE_RES_LOGIC; dec_illegal = 1'b0; end
                    3'b001: if (inst_i[31:25] == 7'b0000000) begin dec_aluop = EXE_SLL_OP; dec_alusel = EXE_RES_SHIFT; dec_illegal = 1'b0; end
                    3'b101: begin
                        if (inst_i[31:25] == 7'b0000000) begin
                            dec_aluop = EXE_SRL_OP; dec_alusel = EXE_RES_SHIFT; dec_illegal = 1'b0;
                        end else if (inst_i[31:25] == 7'b0100000) begin
                            dec_aluop = EXE_SRA_OP; dec_alusel = EXE_RES_SHIFT; dec_illegal = 1'b0;
                        end
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                reg1_read_o = 1'b1;
                reg1_addr_o = 5'd0;
                imm         = XLEN'($signed({inst_i[31:12], 12'b0}));
                dec_aluop   = EXE_OR_OP;
                dec_alusel  = EXE_RES_LOGIC;
                dec_illegal = 1'b0;
            end
            default: dec_illegal = 1'b1;
        endcase
        dec_wreg = !dec_illegal;
        if (dec_illegal) begin
            reg1_read_o = 1'b0;
            reg2_read_o = 1'b0;
            imm         = '0;
        end
    end

    // Returns {hazard, value}; channels are scanned oldest first so the youngest match wins.
    function automatic logic [XLEN:0] sel_operand(
        input logic                    rd,
        input logic [4:0]              addr,
        input logic [XLEN-1:0]         rf,
        input logic [XLEN-1:0]         imm_v,
        input logic [NUM_FWD-1:0]      wreg,
        input logic [5*NUM_FWD-1:0]    wd,
        input logic [XLEN*NUM_FWD-1:0] wdata,
        input logic [NUM_FWD-1:0]      rdy
    );
        logic [XLEN-1:0] v;
        logic            haz;
        v   = rf;
        haz = 1'b0;
        if (!rd) begin
            v = imm_v;
        end else if (addr == 5'd0) begin
            v = '0;
        end else begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (wreg[k] && wd[5*k +: 5] == addr) begin
                    v   = wdata[XLEN*k +: XLEN];
                    haz = !rdy[k];
                end
            end
        end
        return {haz, v};
    endfunction

    always_comb begin
        op1 = sel_operand(reg1_read_o, reg1_addr_o, reg1_data_i, imm,
                          fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_rdy_i);
        op2 = sel_operand(reg2_read_o, reg2_addr_o, reg2_data_i, imm,
                          fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_rdy_i);
        hazard     = inst_valid_i && (op1[XLEN] || op2[XLEN]);
        id_ready_o = (!ex.ex_valid || ex.ex_ready) && !hazard && !flush_i;
        accept     = inst_valid_i && id_ready_o;
    end

    // Flush beats a new accept, which beats a plain drain; otherwise the register holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex.ex_valid <= 1'b0;
            ex.aluop    <= EXE_NOP_OP;
            ex.alusel   <= EXE_RES_NOP;
            ex.reg1     <= '0;
            ex.reg2     <= '0;
            ex.wd       <= '0;
            ex.wreg     <= 1'b0;
            ex.pc       <= '0;
            ex.illegal  <= 1'b0;
        end else if (flush_i) begin
            ex.ex_valid <= 1'b0;
            ex.wreg     <= 1'b0;
            ex.illegal  <= 1'b0;
        end else if (accept) begin
            ex.ex_valid <= 1'b1;
            ex.aluop    <= dec_aluop;
            ex.alusel   <= dec_alusel;
            ex.reg1     <= op1[XLEN-1:0];
            ex.reg2     <= op2[XLEN-1:0];
            ex.wd       <= inst_i[11:7];
            ex.wreg     <= dec_wreg;
            ex.pc       <= pc_i;
            ex.illegal  <= dec_illegal;
        end else if (ex.ex_valid && ex.ex_ready) begin
            ex.ex_valid <= 1'b0;
            ex.wreg     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_o <= '0;
        end else if (hazard && !flush_i && stall_cnt_o != {PERF_W{1'b1}}) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
- Parametrised successor of the decode stage.
- Decodes RV32I/RV64I logic, shift and LUI instructions.
- Selects operands through NUM_FWD prioritised forwarding channels and detects load-use hazards against not-yet-ready sources.
- Registers the result into a valid/ready pipeline register feeding the execute stage; supports flush, back-pressure, an illegal-instruction flag and a saturating stall counter.

Parameters:
XLEN, 32, datapath width; 32 or 64 only.
NUM_FWD, 2, number of forwarding channels; 1..4. Index 0 is the youngest stage.
PERF_W, 16, stall counter width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
inst_valid_i  in  1  fetch presents an instruction
pc_i  in  XLEN  instruction address
inst_i  in  32  instruction word
id_ready_o  out  1  instruction accepted this cycle when high with inst_valid_i
reg1_read_o  out  1  rs1 needed (combinational)
reg2_read_o  out  1  rs2 needed (combinational)
reg1_addr_o  out  5  rs1 address (combinational)
reg2_addr_o  out  5  rs2 address (combinational)
reg1_data_i  in  XLEN  regfile read data, port 1
reg2_data_i  in  XLEN  regfile read data, port 2
fwd_wreg_i  in  NUM_FWD  channel writes a register
fwd_wd_i  in  5*NUM_FWD  channel destination; channel k at bits [5k+4:5k]
fwd_wdata_i  in  XLEN*NUM_FWD  channel result
fwd_rdy_i  in  NUM_FWD  channel result valid; 0 = load pending
flush_i  in  1  kill the pipeline register content
ex_valid_o  out  1  pipeline register holds an instruction
ex_ready_i  in  1  execute consumes the register
aluop_o  out  8  ALU operation (EXE_*_OP encodings)
alusel_o  out  3  result select (EXE_RES_* encodings)
reg1_o  out  XLEN  operand 1
reg2_o  out  XLEN  operand 2
wd_o  out  5  destination register
wreg_o  out  1  write enable
pc_o  out  XLEN  instruction address
illegal_o  out  1  accepted instruction was not decodable
stall_cnt_o  out  PERF_W  load-use stall cycles, saturating

Behaviour:
- Reset (rst=0, asynchronous): ex_valid_o=0, aluop_o=EXE_NOP_OP, alusel_o=EXE_RES_NOP, reg1_o=reg2_o=0, wd_o=0, wreg_o=0, pc_o=0, illegal_o=0, stall_cnt_o=0.
- Decoded set: ORI, ANDI, XORI, SLLI, SRLI, SRAI, OR, AND, XOR, SLL, SRL, SRA, LUI.
- I-type immediate: inst[31:20] sign-extended to XLEN.
- Shift amount: inst[24:20] when XLEN=32; inst[25:20] when XLEN=64.
- Shift legality: SLLI/SRLI require inst[31:26]=000000; SRAI requires inst[31:26]=010000. With XLEN=32, inst[25] must also be 0.
- R-type legality: funct7=0000000, except SRA, which requires 0100000.
- LUI: reg1 = x0; imm = sign-extend({inst[31:12],12'b0}) to XLEN; op is OR.
- Any other encoding: illegal. Accepted normally with aluop NOP, wreg_o=0, illegal_o=1.
- Operand n, in priority order:
  1. Not read: operand = imm.
  2. Address x0: operand = 0. x0 is never forwarded.
  3. Forwarding: the lowest-index channel k with fwd_wreg_i[k] and fwd_wd_i[k]==addr wins. Operand = its wdata when fwd_rdy_i[k]=1; hazard when 0.
  4. Otherwise: operand = regfile data.
- Operand selection is combinational and applies within the same cycle.
- hazard = inst_valid_i AND (a read operand hits a not-ready winning channel). A matching, ready younger channel masks an older not-ready one.
- id_ready_o = (!ex_valid_o | ex_ready_i) & !hazard & !flush_i.
- Per clock edge, in priority order:
  1. flush_i: ex_valid_o←0, wreg_o←0, illegal_o←0.
  2. inst_valid_i & id_ready_o: load all decode outputs; ex_valid_o←1.
  3. ex_valid_o & ex_ready_i: ex_valid_o←0, wreg_o←0. A hazard therefore yields a bubble.
  4. Else: hold all outputs stable.
- Latency: 1 cycle from accept to ex_valid_o.
- Throughput: 1 instruction/cycle with ex_ready_i=1 and no hazards.
- Stall counter: stall_cnt_o increments on each cycle with hazard & !flush_i; it holds at 2^PERF_W-1. Flush does not clear it.

Test Plan:
- Reset, then inst 0x0F006093 (ORI x1,x0,0x0F0), ex_ready_i=1 -> next cycle: ex_valid_o=1, aluop EXE_OR_OP, reg1_o=0, reg2_o=0x0F0, wd_o=1, wreg_o=1.
- LUI 0xABCDE137 -> reg1_o=0, reg2_o=0xABCDE000 (XLEN=32) or 0xFFFFFFFFABCDE000 (XLEN=64), wd_o=2.
- OR 0x0020E1B3 (x3=x1|x2) with ch0 (x1,0x11,rdy=1), ch1 (x1,0x22,rdy=1) and regfile x2=0x5 -> reg1_o=0x11, reg2_o=0x5.
- Same OR with ch0 (x1,rdy=0) held 3 cycles -> id_ready_o=0 and ex_valid_o=0 for those cycles, stall_cnt_o=3. Raise rdy with data 0x7 -> accepted, reg1_o=0x7.
- ex_ready_i=0 with ex_valid_o=1 -> id_ready_o=0 and outputs stable across 4 cycles. flush_i pulse -> ex_valid_o=0, wreg_o=0 next cycle. Asserting rst mid-hold clears everything asynchronously.
- XLEN=32: 0x02009093 (SLLI, inst[25]=1) -> illegal_o=1, wreg_o=0, ex_valid_o=1. A forward to x0 with data 0x55 -> operand is 0.
